// File: rtl/ram_scan_pkg.sv
// rtl/ram_scan_pkg.sv - shared widths, types and mode encoding for the RAM read-scan sequencer
package ram_scan_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SCAN  = 2'd1,
        PAUSE = 2'd2
    } mode_e;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV enabled clk cycles
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_LAST);

    // Count while enabled; a disabled prescaler parks at 0 so the first tick after enable is a full period away.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ram_scan_ctrl.sv
// rtl/ram_scan_ctrl.sv - RAM read-address scanner with tick/step advance and read-data realignment
module ram_scan_ctrl
    import ram_scan_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] rd_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              adv,
    output logic              wrap
);

    localparam int FILL_W = $clog2(RD_LAT + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(RD_LAT);

    mode_e             mode;
    mode_e             mode_next;
    logic [FILL_W-1:0] fill_cnt;
    logic              step_prev;
    logic              step_rise;
    logic              tick;
    logic              tick_en;
    logic              advance;
    addr_t             dly [RD_LAT];

    assign step_rise = step & ~step_prev;

    // The prescaler only runs once the pipeline has filled, so the first auto advance is a full period after FILL.
    assign tick_en = run && (mode != FILL);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .tick  (tick)
    );

    // Mode sequencing and advance decision; step edges are ignored while running rather than queued.
    always_comb begin
        mode_next = mode;
        advance   = 1'b0;
        case (mode)
            FILL:    if (fill_cnt == FILL_LAST) mode_next = run ? SCAN : PAUSE;
            SCAN:    if (!run) mode_next = PAUSE;
            PAUSE:   if (run) mode_next = SCAN;
            default: mode_next = FILL;
        endcase
        if (mode != FILL) begin
            advance = run ? tick : step_rise;
        end
    end

    // Mode register and fill counter covering the RD_LAT+1 cycles before the display pair is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= FILL;
            fill_cnt <= '0;
        end else begin
            mode <= mode_next;
            if (mode == FILL && fill_cnt != FILL_LAST) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Previous step level; resets high so a key held through reset does not count as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_prev <= 1'b1;
        end else begin
            step_prev <= step;
        end
    end

    // Read address counter with advance and wrap pulses aligned to the new address.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdaddress <= '0;
            adv       <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            adv  <= advance;
            wrap <= advance && (rdaddress == '1);
            if (advance) begin
                rdaddress <= rdaddress + 1'b1;
            end
        end
    end

    // Delay the address by the RAM read latency and capture it with rd_q every cycle, so live writes show up.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly[i] <= '0;
            end
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            dly[0] <= rdaddress;
            for (int i = 1; i < RD_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
            disp_addr  <= dly[RD_LAT-1];
            disp_data  <= rd_q;
            disp_valid <= (mode_next != FILL);
        end
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb/tb_ram_scan_ctrl.sv - self-checking bench for ram_scan_ctrl with a 2-cycle RAM model
module tb_ram_scan_ctrl;
    import ram_scan_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int RD_LAT   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              step;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              adv;
    logic              wrap;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] ram_r1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              reset;
        logic              run;
        logic              step;
        logic [ADDR_W-1:0] ra;
        logic              a;
        logic              w;
        logic              dv;
        logic [ADDR_W-1:0] da;
        logic [DATA_W-1:0] dd;
    } vec_t;

    vec_t vecs [18];

    ram_scan_ctrl #(
        .TICK_DIV (TICK_DIV),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .rdaddress  (rdaddress),
        .rd_q       (rd_q),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .adv        (adv),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_r1 <= mem[rdaddress];
        rd_q   <= ram_r1;
    end

    function automatic vec_t mk(input int r, input int ru, input int st, input int ra,
                                input int a, input int w, input int dv, input int da, input int dd);
        vec_t v;
        v.reset = r[0];
        v.run   = ru[0];
        v.step  = st[0];
        v.ra    = ra[ADDR_W-1:0];
        v.a     = a[0];
        v.w     = w[0];
        v.dv    = dv[0];
        v.da    = da[ADDR_W-1:0];
        v.dd    = dd[DATA_W-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n, output int advs);
        advs = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (adv === 1'b1) advs++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int a0, a1, a2, a3;
        int wraps;
        int first;
        int advs;

        for (int i = 0; i < 32; i++) mem[i] = 3'(i % 8);
        reset = 1'b1;
        run   = 1'b1;
        step  = 1'b0;

        //               rst run stp  ra adv wrp dv da dd
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 1, 0, 1, 1, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 0, 1, 0, 0, 1, 0, 0);
        vecs[11] = mk(0, 1, 0, 1, 0, 0, 1, 0, 0);
        vecs[12] = mk(0, 1, 0, 1, 0, 0, 1, 1, 1);
        vecs[13] = mk(0, 1, 0, 2, 1, 0, 1, 1, 1);
        vecs[14] = mk(0, 1, 0, 2, 0, 0, 1, 1, 1);
        vecs[15] = mk(0, 1, 0, 2, 0, 0, 1, 1, 1);
        vecs[16] = mk(0, 1, 0, 2, 0, 0, 1, 2, 2);
        vecs[17] = mk(0, 1, 0, 3, 1, 0, 1, 2, 2);

        for (int k = 0; k < 18; k++) begin
            reset = vecs[k].reset;
            run   = vecs[k].run;
            step  = vecs[k].step;
            cyc();
            chk($sformatf("v%0d rdaddress", k), 32'(rdaddress), 32'(vecs[k].ra));
            chk($sformatf("v%0d adv", k), 32'(adv), 32'(vecs[k].a));
            chk($sformatf("v%0d wrap", k), 32'(wrap), 32'(vecs[k].w));
            chk($sformatf("v%0d disp_valid", k), 32'(disp_valid), 32'(vecs[k].dv));
            chk($sformatf("v%0d disp_addr", k), 32'(disp_addr), 32'(vecs[k].da));
            chk($sformatf("v%0d disp_data", k), 32'(disp_data), 32'(vecs[k].dd));
        end

        // Scan up to 31, then the wrapping advance.
        wraps = 0;
        n = 0;
        while (rdaddress !== 5'd31 && n < 200) begin
            cyc();
            n++;
            if (wrap === 1'b1) wraps++;
        end
        chk("reach_31_in_time", 32'(n < 200), 1);
        chk("no_early_wrap", 32'(wraps), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre_wrap_adv", 32'(adv), 0);
        end
        cyc();
        chk("wrap_rdaddress", 32'(rdaddress), 0);
        chk("wrap_adv", 32'(adv), 1);
        chk("wrap_pulse", 32'(wrap), 1);
        chk("wrap_disp_addr", 32'(disp_addr), 31);
        chk("wrap_disp_data", 32'(disp_data), 7);
        cyc();
        chk("wrap_one_cycle", 32'(wrap), 0);
        cyc();
        chk("wrap_disp_addr_hold", 32'(disp_addr), 31);
        cyc();
        chk("post_wrap_disp_addr", 32'(disp_addr), 0);
        chk("post_wrap_disp_data", 32'(disp_data), 0);

        // Pause: the pending tick must not advance once run drops.
        run = 1'b0;
        run_n(4, advs);
        chk("pause_no_adv", 32'(advs), 0);
        chk("pause_rdaddress", 32'(rdaddress), 0);

        // Two long step pulses give exactly two advances.
        step = 1'b1; run_n(5, a0);
        step = 1'b0; run_n(3, a1);
        step = 1'b1; run_n(5, a2);
        step = 1'b0; run_n(3, a3);
        chk("step_pulse_advs", 32'(a0 + a1 + a2 + a3), 2);
        chk("step_pulse_rdaddress", 32'(rdaddress), 2);

        // Step on to address 5, then live write.
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc();
            step = 1'b0; cyc();
        end
        chk("step_to_5", 32'(rdaddress), 5);
        run_n(4, advs);
        chk("paused5_disp_addr", 32'(disp_addr), 5);
        chk("paused5_disp_data", 32'(disp_data), 5);
        mem[5] = 3'd2;
        run_n(3, advs);
        chk("live_write_data", 32'(disp_data), 2);
        chk("live_write_addr", 32'(disp_addr), 5);
        chk("live_write_adv", 32'(advs), 0);
        mem[5] = 3'd5;

        // Re-enable run with a step edge in the middle: edge ignored, first tick a full period out.
        run = 1'b1;
        advs = 0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) step = 1'b1;
            cyc();
            if (adv === 1'b1) begin
                advs++;
                if (first == 0) first = i;
            end
        end
        chk("run_step_ignored_advs", 32'(advs), 2);
        chk("run_first_tick_cycle", 32'(first), 4);
        chk("run_rdaddress", 32'(rdaddress), 7);

        // Step held high through reset produces no advance.
        run = 1'b0;
        reset = 1'b1;
        run_n(3, advs);
        chk("held_reset_rdaddress", 32'(rdaddress), 0);
        chk("held_reset_valid", 32'(disp_valid), 0);
        reset = 1'b0;
        run_n(6, advs);
        chk("held_step_no_adv", 32'(advs), 0);
        chk("held_step_rdaddress", 32'(rdaddress), 0);
        step = 1'b0;

        // Reset mid-scan at address 17 with the prescaler at 2.
        run = 1'b1;
        n = 0;
        while (rdaddress !== 5'd17 && n < 300) begin
            cyc();
            n++;
        end
        chk("reach_17_in_time", 32'(n < 300), 1);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("midscan_reset_rdaddress", 32'(rdaddress), 0);
        chk("midscan_reset_valid", 32'(disp_valid), 0);
        chk("midscan_reset_disp_addr", 32'(disp_addr), 0);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 2) chk("midscan_fill_valid_low", 32'(disp_valid), 0);
            if (i == 3) chk("midscan_fill_valid_high", 32'(disp_valid), 1);
            if (adv === 1'b1 && first == 0) first = i;
        end
        chk("midscan_first_adv_cycle", 32'(first), 7);
        chk("midscan_rdaddress", 32'(rdaddress), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
